// File: rtl/rr_replay_unpack_pkg.sv
// ----------------------------------------------------------------------------
// rr_replay_unpack_pkg
// Shared constants, types and helper functions for the replay-side unpacker.
//
// Contents:
//   RR_CHANNEL_WIDTH_BITS    - bit width of one entry of the channel width list
//   LOGB/LOGE_CHANNEL_CNT    - bitmap widths of the replay packet header
//   SHUFFLED_CHANNEL_WIDTHS  - payload width per channel, shuffled order
//   CH_DATA_WIDTH / WIDTH / OFFSET_WIDTH - derived bus widths
//   ch_offset()              - fixed (non-compacted) offset of a channel on ch_data
//   get_len()                - aligned packet length for a given LOGB bitmap
//   state_t                  - unpacker FSM states
// ----------------------------------------------------------------------------
package rr_replay_unpack_pkg;

    localparam int RR_CHANNEL_WIDTH_BITS = 8;
    localparam int LOGB_CHANNEL_CNT      = 14;
    localparam int LOGE_CHANNEL_CNT      = 25;
    localparam int HDR_WIDTH             = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
    // Packet lengths reported by the trace reader are rounded up to this.
    localparam int RR_LEN_ALIGN          = 8;

    localparam logic [RR_CHANNEL_WIDTH_BITS-1:0] SHUFFLED_CHANNEL_WIDTHS [LOGB_CHANNEL_CNT] = '{
        8'd32, 8'd16, 8'd32, 8'd8,  8'd64, 8'd1,  8'd24,
        8'd32, 8'd4,  8'd16, 8'd40, 8'd2,  8'd8,  8'd12
    };

    function automatic int ch_width_sum();
        int acc;
        acc = 0;
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            acc += int'(SHUFFLED_CHANNEL_WIDTHS[i]);
        end
        return acc;
    endfunction

    function automatic int calc_width();
        return ch_width_sum() + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
    endfunction

    localparam int CH_DATA_WIDTH = ch_width_sum();
    localparam int WIDTH         = calc_width();
    localparam int OFFSET_WIDTH  = $clog2(WIDTH + 1);

    // Prefix sum of widths of channels 0..idx-1: where channel idx sits on ch_data.
    function automatic int ch_offset(input int idx);
        int acc;
        acc = 0;
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            if (i < idx) begin
                acc += int'(SHUFFLED_CHANNEL_WIDTHS[i]);
            end
        end
        return acc;
    endfunction

    // Header plus selected payloads, rounded up to RR_LEN_ALIGN bits.
    function automatic logic [OFFSET_WIDTH-1:0] get_len(input logic [LOGB_CHANNEL_CNT-1:0] logb);
        int len;
        len = HDR_WIDTH;
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            if (logb[i]) begin
                len += int'(SHUFFLED_CHANNEL_WIDTHS[i]);
            end
        end
        len = ((len + RR_LEN_ALIGN - 1) / RR_LEN_ALIGN) * RR_LEN_ALIGN;
        return OFFSET_WIDTH'(len);
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rr_replay_unpack_offsets.sv
// ----------------------------------------------------------------------------
// rr_replay_unpack_offsets
// Combinational: maps a LOGB bitmap to the bit offset inside a packet where
// each channel's compacted payload starts. Payloads follow the LOGB and LOGE
// bitmaps and appear in channel order, skipping channels whose LOGB bit is 0.
// The offset of an unselected channel is where it would have started; callers
// must ignore it.
//
// Ports:
//   i_logb  in   LOGB_CHANNEL_CNT                 logged-begin bitmap
//   o_base  out  LOGB_CHANNEL_CNT x OFFSET_WIDTH  per-channel payload offset
// ----------------------------------------------------------------------------
module rr_replay_unpack_offsets
    import rr_replay_unpack_pkg::*;
(
    input  logic [LOGB_CHANNEL_CNT-1:0]                   i_logb,
    output logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] o_base
);

    always_comb begin
        logic [OFFSET_WIDTH-1:0] w_acc;
        w_acc  = OFFSET_WIDTH'(HDR_WIDTH);
        o_base = '0;
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            o_base[i] = w_acc;
            if (i_logb[i]) begin
                w_acc = w_acc + OFFSET_WIDTH'(SHUFFLED_CHANNEL_WIDTHS[i]);
            end
        end
    end

endmodule

// File: rtl/rr_replay_unpack.sv
// ----------------------------------------------------------------------------
// rr_replay_unpack
// Replay-path unpacker between the trace reader and the per-channel replay
// FIFOs. Takes one variable-width packet {payloads, LOGE, LOGB} (LOGB in the
// LSBs), spreads the compacted payloads onto fixed per-channel lanes and
// presents each channel plus the LOGE mask with its own valid/ready pair.
//
// Ports:
//   clk, sync_rst          clock, synchronous active-high reset
//   in_valid/in_ready      packet handshake (in_ready is combinational)
//   in_data  [WIDTH]       packet; bits beyond the packet length are ignored
//   in_width [OFFSET_WIDTH] reported packet length
//   ch_valid/ch_ready      per-channel handshakes
//   ch_data  [CH_DATA_WIDTH] channel payloads at fixed prefix-sum offsets
//   loge_valid/loge_ready  LOGE event handshake
//   loge_mask [LOGE]       LOGE bitmap of the held packet
//   pkt_cnt  [64]          packets accepted since reset
//
// Optional feature, macro RR_REPLAY_UNPACK_CHECK_EN: compares in_width with
// the aligned expected length on every accepted packet and adds width_err
// (sticky) and width_err_cnt (32-bit, saturating). Packets are forwarded
// regardless. Without the macro in_width is unused.
// ----------------------------------------------------------------------------
module rr_replay_unpack
    import rr_replay_unpack_pkg::*;
(
    input  logic                        clk,
    input  logic                        sync_rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [OFFSET_WIDTH-1:0]     in_width,
    output logic [LOGB_CHANNEL_CNT-1:0] ch_valid,
    input  logic [LOGB_CHANNEL_CNT-1:0] ch_ready,
    output logic [CH_DATA_WIDTH-1:0]    ch_data,
    output logic                        loge_valid,
    input  logic                        loge_ready,
    output logic [LOGE_CHANNEL_CNT-1:0] loge_mask,
    output logic [63:0]                 pkt_cnt
`ifdef RR_REPLAY_UNPACK_CHECK_EN
    ,
    output logic                        width_err,
    output logic [31:0]                 width_err_cnt
`endif
);

    // One pending bit per channel plus the LOGE part on top.
    localparam int NPART = LOGB_CHANNEL_CNT + 1;

    state_t                         r_state;
    logic                           r_live;
    logic [NPART-1:0]               r_pending;
    logic [CH_DATA_WIDTH-1:0]       r_ch_data;
    logic [LOGE_CHANNEL_CNT-1:0]    r_loge_mask;
    logic [63:0]                    r_pkt_cnt;

    logic [LOGB_CHANNEL_CNT-1:0]    w_logb;
    logic [LOGE_CHANNEL_CNT-1:0]    w_loge;
    logic [NPART-1:0]               w_pending_left;
    logic                           w_in_ready;
    logic                           w_accept;
    logic [NPART-1:0]               w_pending_next;
    logic [CH_DATA_WIDTH-1:0]       w_ch_data_next;
    logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] w_base;

    assign w_logb = in_data[LOGB_CHANNEL_CNT-1:0];
    assign w_loge = in_data[HDR_WIDTH-1:LOGB_CHANNEL_CNT];

    // Parts that will still be undelivered after this edge.
    assign w_pending_left = r_pending & ~{loge_ready, ch_ready};

    // Accept when nothing will be left pending, so a packet can be taken in
    // the same cycle the last part of the previous one drains. r_live keeps
    // in_ready low while in reset and releases it one cycle later.
    assign w_in_ready     = r_live && ((r_state == ST_IDLE) || (w_pending_left == '0));
    assign w_accept       = in_valid && w_in_ready;
    assign w_pending_next = w_accept ? {(|w_loge), w_logb} : w_pending_left;

    rr_replay_unpack_offsets u_offsets (
        .i_logb (w_logb),
        .o_base (w_base)
    );

    // Unselected lanes keep their previous payload.
    genvar gi;
    generate
        for (gi = 0; gi < LOGB_CHANNEL_CNT; gi++) begin : g_ch
            localparam int CH_W   = int'(SHUFFLED_CHANNEL_WIDTHS[gi]);
            localparam int CH_OFF = ch_offset(gi);
            assign w_ch_data_next[CH_OFF +: CH_W] = (w_accept && w_logb[gi])
                ? in_data[w_base[gi] +: CH_W]
                : r_ch_data[CH_OFF +: CH_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_pending   <= '0;
            r_ch_data   <= '0;
            r_loge_mask <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            r_live    <= 1'b1;
            r_pending <= w_pending_next;
            r_ch_data <= w_ch_data_next;
            // Empty packets and fully drained packets both land in IDLE.
            case (r_state)
                ST_IDLE: r_state <= (|w_pending_next) ? ST_HOLD : ST_IDLE;
                ST_HOLD: r_state <= (|w_pending_next) ? ST_HOLD : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) begin
                r_loge_mask <= w_loge;
                r_pkt_cnt   <= r_pkt_cnt + 64'd1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign ch_valid   = r_pending[LOGB_CHANNEL_CNT-1:0];
    assign loge_valid = r_pending[LOGB_CHANNEL_CNT];
    assign ch_data    = r_ch_data;
    assign loge_mask  = r_loge_mask;
    assign pkt_cnt    = r_pkt_cnt;

`ifdef RR_REPLAY_UNPACK_CHECK_EN
    logic                    r_width_err;
    logic [31:0]             r_width_err_cnt;
    logic [OFFSET_WIDTH-1:0] w_exp_len;
    logic                    w_width_bad;

    assign w_exp_len   = get_len(w_logb);
    assign w_width_bad = w_accept && (in_width != w_exp_len);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_width_err     <= 1'b0;
            r_width_err_cnt <= '0;
        end else if (w_width_bad) begin
            r_width_err <= 1'b1;
            if (r_width_err_cnt != 32'hFFFF_FFFF) begin
                r_width_err_cnt <= r_width_err_cnt + 32'd1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!sync_rst && w_width_bad) begin
            $error("rr_replay_unpack: in_width %0d, expected %0d", in_width, w_exp_len);
        end
    end
`endif

    assign width_err     = r_width_err;
    assign width_err_cnt = r_width_err_cnt;
`else
    logic w_unused_width;
    assign w_unused_width = ^in_width;
`endif

endmodule

// File: tb/tb_rr_replay_unpack.sv
`timescale 1ns/1ps
module tb_rr_replay_unpack;

    localparam int NB  = 14;
    localparam int NE  = 25;
    localparam int HDR = NB + NE;
    localparam int CW  = 291;
    localparam int PW  = CW + HDR;
    localparam int OW  = 9;
    localparam int TW [NB] = '{32, 16, 32, 8, 64, 1, 24, 32, 4, 16, 40, 2, 8, 12};

    logic          clk = 1'b0;
    logic          sync_rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic [OW-1:0] in_width;
    logic [NB-1:0] ch_valid;
    logic [NB-1:0] ch_ready;
    logic [CW-1:0] ch_data;
    logic          loge_valid;
    logic          loge_ready;
    logic [NE-1:0] loge_mask;
    logic [63:0]   pkt_cnt;
`ifdef RR_REPLAY_UNPACK_CHECK_EN
    logic          width_err;
    logic [31:0]   width_err_cnt;
`endif

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [63:0]   pay [NB];
    logic [CW-1:0] exp_ch;
    logic [NB-1:0] lb;
    logic [NE-1:0] le;
    int            acc;

    always #5 clk = ~clk;

    rr_replay_unpack dut (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_width   (in_width),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_data    (ch_data),
        .loge_valid (loge_valid),
        .loge_ready (loge_ready),
        .loge_mask  (loge_mask),
        .pkt_cnt    (pkt_cnt)
`ifdef RR_REPLAY_UNPACK_CHECK_EN
        ,
        .width_err     (width_err),
        .width_err_cnt (width_err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fixed lane offset of channel i on ch_data.
    function automatic int foff(input int idx);
        int s;
        s = 0;
        for (int j = 0; j < idx; j++) s += TW[j];
        return s;
    endfunction

    // Build a packet: LOGB, LOGE, then selected payloads; filler above is random.
    function automatic logic [PW-1:0] pack(input logic [NB-1:0] b_map, input logic [NE-1:0] e_map);
        logic [PW-1:0] p;
        int pos;
        for (int b = 0; b < PW; b++) p[b] = 1'($urandom);
        p[NB-1:0]  = b_map;
        p[HDR-1:NB] = e_map;
        pos = HDR;
        for (int i = 0; i < NB; i++) begin
            if (b_map[i]) begin
                for (int b = 0; b < TW[i]; b++) p[pos + b] = pay[i][b];
                pos += TW[i];
            end
        end
        return p;
    endfunction

    function automatic logic [OW-1:0] tb_len(input logic [NB-1:0] b_map);
        int len;
        len = HDR;
        for (int i = 0; i < NB; i++) if (b_map[i]) len += TW[i];
        len = ((len + 7) / 8) * 8;
        return OW'(len);
    endfunction

    task automatic send(input logic [NB-1:0] b_map, input logic [NE-1:0] e_map);
        in_data  = pack(b_map, e_map);
        in_width = tb_len(b_map);
        in_valid = 1'b1;
    endtask

    task automatic upd_exp(input logic [NB-1:0] b_map);
        for (int i = 0; i < NB; i++) begin
            if (b_map[i]) begin
                for (int b = 0; b < TW[i]; b++) exp_ch[foff(i) + b] = pay[i][b];
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sync_rst   = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_width   = '0;
        ch_ready   = '1;
        loge_ready = 1'b1;
        exp_ch     = '0;
        for (int i = 0; i < NB; i++) pay[i] = '0;

        // Reset state
        repeat (3) step();
        chk("rst_in_ready",   CW'(in_ready),   CW'(0));
        chk("rst_ch_valid",   CW'(ch_valid),   CW'(0));
        chk("rst_loge_valid", CW'(loge_valid), CW'(0));
        chk("rst_ch_data",    ch_data,         '0);
        chk("rst_loge_mask",  CW'(loge_mask),  CW'(0));
        chk("rst_pkt_cnt",    CW'(pkt_cnt),    CW'(0));
        sync_rst = 1'b0;
        step();
        chk("in_ready_after_rst", CW'(in_ready), CW'(1));

        // Single channel-0 packet
        pay[0] = 64'hDEADBEEF;
        send(14'h0001, '0);
        step();
        upd_exp(14'h0001);
        chk("t1_ch_valid", CW'(ch_valid),      CW'(14'h0001));
        chk("t1_ch0_data", CW'(ch_data[31:0]), CW'(32'hDEADBEEF));
        chk("t1_pkt_cnt",  CW'(pkt_cnt),       CW'(1));
        chk("t1_in_ready", CW'(in_ready),      CW'(1));
        in_valid = 1'b0;
        step();
        chk("t1_drained", CW'(ch_valid), CW'(0));

        // Channels 0 and 2 with channel 2 back-pressured for 5 cycles
        pay[0] = 64'h11112222;
        pay[2] = 64'h33334444;
        ch_ready[2] = 1'b0;
        send(14'h0005, '0);
        step();
        upd_exp(14'h0005);
        chk("t2_ch_valid", CW'(ch_valid), CW'(14'h0005));
        chk("t2_ch_data",  ch_data,       exp_ch);
        chk("t2_in_ready", CW'(in_ready), CW'(0));
        pay[1] = 64'hABCD;
        send(14'h0002, '0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_hold_valid", CW'(ch_valid), CW'(14'h0004));
            chk("t2_hold_data",  ch_data,       exp_ch);
            chk("t2_hold_ready", CW'(in_ready), CW'(0));
        end
        chk("t2_hold_cnt", CW'(pkt_cnt), CW'(2));
        ch_ready[2] = 1'b1;
        #1;
        chk("t2_in_ready_release", CW'(in_ready), CW'(1));
        step();
        upd_exp(14'h0002);
        chk("t2_next_valid", CW'(ch_valid), CW'(14'h0002));
        chk("t2_next_data",  ch_data,       exp_ch);
        chk("t2_next_cnt",   CW'(pkt_cnt),  CW'(3));
        in_valid = 1'b0;
        step();
        chk("t2_drained", CW'(ch_valid), CW'(0));

        // 100 back-to-back random packets, all consumers ready
        acc = 0;
        for (int n = 0; n < 100; n++) begin
            lb = NB'($urandom);
            if (n % 10 == 0) lb = '1;
            if (n % 7 == 3)  lb = '0;
            le = (n % 4 == 1) ? '0 : NE'($urandom);
            for (int i = 0; i < NB; i++) pay[i] = {$urandom, $urandom};
            send(lb, le);
            #1;
            if (in_ready) acc++;
            step();
            upd_exp(lb);
            chk("rnd_ch_valid",   CW'(ch_valid),   CW'(lb));
            chk("rnd_loge_valid", CW'(loge_valid), CW'(|le));
            if (|le) chk("rnd_loge_mask", CW'(loge_mask), CW'(le));
            chk("rnd_ch_data", ch_data, exp_ch);
        end
        in_valid = 1'b0;
        chk("rnd_accepted", CW'(acc),     CW'(100));
        chk("rnd_pkt_cnt",  CW'(pkt_cnt), CW'(103));
        step();

        // Reset while three channels and LOGE are pending
        ch_ready   = '0;
        loge_ready = 1'b0;
        pay[0] = 64'hA5A5A5A5;
        pay[1] = 64'h5A5A;
        pay[4] = 64'h0123456789ABCDEF;
        send(14'h0013, 25'h5);
        step();
        upd_exp(14'h0013);
        chk("t5_hold_valid", CW'(ch_valid),   CW'(14'h0013));
        chk("t5_hold_loge",  CW'(loge_valid), CW'(1));
        chk("t5_hold_data",  ch_data,         exp_ch);
        in_valid = 1'b0;
        sync_rst = 1'b1;
        step();
        chk("t5_rst_ch_valid", CW'(ch_valid),   CW'(0));
        chk("t5_rst_loge",     CW'(loge_valid), CW'(0));
        chk("t5_rst_cnt",      CW'(pkt_cnt),    CW'(0));
        chk("t5_rst_data",     ch_data,         '0);
        chk("t5_rst_in_ready", CW'(in_ready),   CW'(0));
        exp_ch     = '0;
        sync_rst   = 1'b0;
        ch_ready   = '1;
        loge_ready = 1'b1;
        step();
        chk("t5_in_ready_after", CW'(in_ready), CW'(1));

        // Empty packet then LOGE-only packet (LOGE consumer stalls one cycle)
        send('0, '0);
        step();
        chk("t4_empty_ch_valid", CW'(ch_valid),   CW'(0));
        chk("t4_empty_loge",     CW'(loge_valid), CW'(0));
        chk("t4_empty_ready",    CW'(in_ready),   CW'(1));
        chk("t4_empty_cnt",      CW'(pkt_cnt),    CW'(1));
        loge_ready = 1'b0;
        send('0, 25'h1);
        step();
        in_valid = 1'b0;
        chk("t4_loge_valid",  CW'(loge_valid), CW'(1));
        chk("t4_loge_chv",    CW'(ch_valid),   CW'(0));
        chk("t4_loge_mask",   CW'(loge_mask),  CW'(25'h1));
        chk("t4_loge_cnt",    CW'(pkt_cnt),    CW'(2));
        chk("t4_loge_stall",  CW'(in_ready),   CW'(0));
        step();
        chk("t4_loge_held",   CW'(loge_valid), CW'(1));
        loge_ready = 1'b1;
        step();
        chk("t4_loge_done",   CW'(loge_valid), CW'(0));
        chk("t4_final_cnt",   CW'(pkt_cnt),    CW'(2));

`ifdef RR_REPLAY_UNPACK_CHECK_EN
        // Wrong reported width: flagged, but the payload still goes through
        chk("chk_err_clear", CW'(width_err), CW'(0));
        pay[0] = 64'hCAFEF00D;
        send(14'h0001, '0);
        in_width = tb_len(14'h0001) + OW'(8);
        step();
        in_valid = 1'b0;
        chk("chk_width_err",     CW'(width_err),     CW'(1));
        chk("chk_width_err_cnt", CW'(width_err_cnt), CW'(1));
        chk("chk_data",          CW'(ch_data[31:0]), CW'(32'hCAFEF00D));
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
